ad7383_axis_sample_sink: RTL
============================

# ad7383_axis_sample_sink

AXI4-Stream slave that terminates the AD7383 sample stream on the fabric side. Accepts 32-bit beats carrying one simultaneous channel-A/B conversion pair, buffers them in a small FIFO, and presents them unpacked as 16-bit channel samples on a valid/ready interface to downstream processing. Also checks packet framing against an expected beats-per-TLAST length and counts completed packets.

## Interface
- FIFO_DEPTH, 8: buffer depth in beats; power of two, ≥2.
- PKT_LEN, 1: expected beats per packet (TLAST on beat PKT_LEN-1); ≥1.

- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXIS_TDATA  in  32  [31:16] = channel A, [15:0] = channel B, two's complement.
- S_AXIS_TVALID  in  1  upstream beat valid.
- S_AXIS_TLAST  in  1  last beat of packet.
- S_AXIS_TREADY  out  1  sink can accept a beat.
- sample_a_o  out  16  channel-A sample at FIFO head.
- sample_b_o  out  16  channel-B sample at FIFO head.
- sample_last_o  out  1  TLAST bit stored with head beat.
- sample_valid_o  out  1  head sample present.
- sample_ready_i  in  1  downstream consumes head.
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  occupied entries.
- pkt_count_o  out  32  packets closed (TLAST beats accepted), wraps 2^32-1 → 0.
- len_err_o  out  1  sticky framing error.
- len_err_clr_i  in  1  synchronous clear of len_err_o.

## Operation
- Accept = TVALID && TREADY at a rising edge; entry {TDATA, TLAST} written at write pointer.
- Pop = sample_valid_o && sample_ready_i; read pointer advances.
- sample_valid_o = level ≠ 0; sample_* outputs driven from entry at read pointer (no output register).
- S_AXIS_TREADY registered: next value = (next level < FIFO_DEPTH). When full it is 0 even if a pop occurs that cycle; no write-through when full, no bypass when empty.
- Simultaneous accept and pop: level unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH; level tracked separately (0..FIFO_DEPTH).
- Framing (input side, accepted beats only), beat index bidx from 0:
  - TLAST on bidx = PKT_LEN-1: packet ok; pkt_count +1; bidx ← 0.
  - TLAST on bidx < PKT_LEN-1: len_err set; pkt_count +1; bidx ← 0.
  - no TLAST on bidx = PKT_LEN-1: len_err set; bidx held at PKT_LEN-1 until next TLAST beat, which closes packet (pkt_count +1, no further error set needed).
  - no TLAST, bidx < PKT_LEN-1: bidx +1.
- len_err_clr_i clears len_err_o; if set condition and clear coincide, set wins.
- Data not altered; framing errors do not drop or modify beats.

## Timing
- Reset (async assert): pointers, level, bidx, pkt_count_o, len_err_o = 0; S_AXIS_TREADY = 0; sample_valid_o = 0. First rising edge after deassert drives TREADY = 1.
- Latency: beat accepted at edge N appears on sample_* with sample_valid_o high from edge N to following cycle (1 cycle).
- TREADY falls at the edge that makes level = FIFO_DEPTH; rises at the edge after a pop from full.
- pkt_count_o, len_err_o update at the edge that accepts the relevant beat.
- Reset mid-packet: FIFO contents discarded, bidx restarts at 0, counters cleared.

## Structure
- Shared package ad7383_pkg: ADC_SAMPLE_W = 16, AXIS_DATA_W = 32, typedef adc_pair_t (packed struct a, b of 16 bits, a in MSBs), function packing/unpacking adc_pair_t ↔ 32-bit word.
- Sub-module ad7383_sync_fifo (single clock, WIDTH/DEPTH parameters, push/pop, full/empty/level, async active-low reset); top holds TREADY register and framing checker.

## Test plan
- Reset then single beat 0x1234_ABCD, TLAST=1 → next cycle sample_a_o=0x1234, sample_b_o=0xABCD, sample_last_o=1, pkt_count_o=1, len_err_o=0.
- sample_ready_i=0, 9 beats offered back-to-back, DEPTH=8 → 8 accepted, TREADY=0 after 8th, level=8; one pop → TREADY=1 next cycle, 9th accepted; data order preserved.
- Continuous TVALID/ready, 100 beats, random TREADY/ready toggling → output sequence equals input sequence, no loss/duplication.
- PKT_LEN=4: packets of 4, 2, 5 beats → pkt_count_o=3; len_err_o set at 2nd beat of packet 2; clear, then set again at 4th beat (non-TLAST) of packet 3.
- len_err_clr_i asserted same cycle as a new error → len_err_o remains 1.
- ARESETN asserted with level=5 mid-packet → immediately sample_valid_o=0, TREADY=0, counters 0; after release, fresh packet counted correctly.

Source files
------------

// File: rtl/ad7383_pkg.sv
// ad7383_pkg: shared widths, the A/B sample pair type and helpers that
// convert between the pair and the 32-bit AXI4-Stream word.
`default_nettype none

package ad7383_pkg;

   localparam int ADC_SAMPLE_W = 16;
   localparam int AXIS_DATA_W  = 32;

   // Channel A occupies the upper half of the stream word.
   typedef struct packed {
      logic [ADC_SAMPLE_W-1:0] a;
      logic [ADC_SAMPLE_W-1:0] b;
   } adc_pair_t;

   typedef struct packed {
      adc_pair_t pair;
      logic      last;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   function automatic logic [AXIS_DATA_W-1:0] pack_pair(input adc_pair_t p);
      return {p.a, p.b};
   endfunction

   function automatic adc_pair_t unpack_pair(input logic [AXIS_DATA_W-1:0] w);
      adc_pair_t p;
      p.a = w[AXIS_DATA_W-1 -: ADC_SAMPLE_W];
      p.b = w[ADC_SAMPLE_W-1:0];
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ad7383_sync_fifo.sv
// ad7383_sync_fifo: single-clock FIFO with unregistered head output and an
// explicit occupancy counter (0..DEPTH) kept apart from the wrapping pointers.
`default_nettype none

module ad7383_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               wdata,
   output logic [WIDTH-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     level,
   output logic [$clog2(DEPTH+1)-1:0]     level_next
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   // A push into a full FIFO is dropped even when a pop frees a slot the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_comb begin
      level_next = level;
      case ({do_push, do_pop})
         2'b10:   level_next = level + LVL_W'(1);
         2'b01:   level_next = level - LVL_W'(1);
         default: level_next = level;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level_next;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

`default_nettype wire

// File: rtl/ad7383_axis_sample_sink.sv
// ad7383_axis_sample_sink: AXI4-Stream sink for AD7383 A/B pairs with FIFO
// buffering, unpacked sample output and TLAST framing check / packet counter.
`default_nettype none

module ad7383_axis_sample_sink
   import ad7383_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int PKT_LEN    = 1
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [AXIS_DATA_W-1:0]            S_AXIS_TDATA,
   input  logic                              S_AXIS_TVALID,
   input  logic                              S_AXIS_TLAST,
   output logic                              S_AXIS_TREADY,
   output logic [ADC_SAMPLE_W-1:0]           sample_a_o,
   output logic [ADC_SAMPLE_W-1:0]           sample_b_o,
   output logic                              sample_last_o,
   output logic                              sample_valid_o,
   input  logic                              sample_ready_i,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
   output logic [31:0]                       pkt_count_o,
   output logic                              len_err_o,
   input  logic                              len_err_clr_i
);

   localparam int                LVL_W    = $clog2(FIFO_DEPTH+1);
   localparam int                BIDX_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(PKT_LEN-1);

   fifo_entry_t       wr_entry;
   fifo_entry_t       rd_entry;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  level_next;
   logic              tready;
   logic              accept;
   logic              pop;

   logic [BIDX_W-1:0] bidx;
   logic [BIDX_W-1:0] bidx_next;
   logic [31:0]       pkt_count_next;
   logic              err_set;
   logic              len_err_next;

   assign S_AXIS_TREADY  = tready;
   assign accept         = S_AXIS_TVALID && tready && !fifo_full;
   assign pop            = !fifo_empty && sample_ready_i;

   assign wr_entry.pair  = unpack_pair(S_AXIS_TDATA);
   assign wr_entry.last  = S_AXIS_TLAST;

   assign sample_a_o     = rd_entry.pair.a;
   assign sample_b_o     = rd_entry.pair.b;
   assign sample_last_o  = rd_entry.last;
   assign sample_valid_o = !fifo_empty;

   ad7383_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (ACLK),
      .rst_n      (ARESETN),
      .push       (accept),
      .pop        (pop),
      .wdata      (wr_entry),
      .rdata      (rd_entry),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .level      (fifo_level_o),
      .level_next (level_next)
   );

   // Ready looks one cycle ahead so it is already low on the edge that fills the FIFO.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) tready <= 1'b0;
      else          tready <= (level_next < LVL_W'(FIFO_DEPTH));
   end

   // An over-long packet parks bidx at the last index until TLAST arrives,
   // so that closing beat lands on the "ok" branch and raises no second error.
   always_comb begin
      bidx_next      = bidx;
      pkt_count_next = pkt_count_o;
      err_set        = 1'b0;
      if (accept) begin
         if (S_AXIS_TLAST) begin
            pkt_count_next = pkt_count_o + 32'd1;
            bidx_next      = '0;
            err_set        = (bidx != LAST_IDX);
         end else if (bidx == LAST_IDX) begin
            err_set        = 1'b1;
         end else begin
            bidx_next      = bidx + BIDX_W'(1);
         end
      end
      len_err_next = err_set || (len_err_o && !len_err_clr_i);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         bidx        <= '0;
         pkt_count_o <= '0;
         len_err_o   <= 1'b0;
      end else begin
         bidx        <= bidx_next;
         pkt_count_o <= pkt_count_next;
         len_err_o   <= len_err_next;
      end
   end

endmodule

`default_nettype wire
